// File: rtl/count24_pkg.sv
// Shared types, constants and BCD / 7-segment helpers for the count_24 clock.
package count24_pkg;

  typedef logic [3:0] bcd_t;

  // Time of day, most significant digit first, so the packed value reads as HHMMSS in hex.
  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } time_t;

  localparam int unsigned HOUR_MAX    = 23;
  localparam int unsigned MIN_SEC_MAX = 59;

  // Two-digit BCD forms of the wrap limits.
  localparam logic [7:0] HOUR_MAX_BCD    = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));
  localparam logic [7:0] MIN_SEC_MAX_BCD = 8'(((MIN_SEC_MAX / 10) << 4) | (MIN_SEC_MAX % 10));

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Digit to active-low segments; non-decimal codes blank the digit.
  function automatic logic [7:0] bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One up/down step of a two-digit BCD field that wraps between 00 and max_bcd.
  function automatic logic [7:0] bcd2_step(input logic [7:0] pair, input logic down,
                                           input logic [7:0] max_bcd);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = pair[7:4];
    lo = pair[3:0];
    if (!down) begin
      if (pair == max_bcd) begin
        hi = 4'd0;
        lo = 4'd0;
      end else if (lo == 4'd9) begin
        hi = hi + 4'd1;
        lo = 4'd0;
      end else begin
        lo = lo + 4'd1;
      end
    end else begin
      if (pair == 8'h00) begin
        hi = max_bcd[7:4];
        lo = max_bcd[3:0];
      end else if (lo == 4'd0) begin
        hi = hi - 4'd1;
        lo = 4'd9;
      end else begin
        lo = lo - 4'd1;
      end
    end
    return {hi, lo};
  endfunction

  // True when the next step of the field wraps (carry when counting up, borrow when down).
  function automatic logic bcd2_wraps(input logic [7:0] pair, input logic down,
                                      input logic [7:0] max_bcd);
    return down ? (pair == 8'h00) : (pair == max_bcd);
  endfunction

endpackage

// File: rtl/count_24_sec_tick.sv
// Prescaler: divides CLK down to a one-cycle tick every SEC1_MAX cycles.
// With COUNT24_DP_BLINK_EN defined the running count is exported for the dp blink.
module sec_tick import count24_pkg::*; #(
  parameter int unsigned SEC1_MAX = 100000000
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
`ifdef COUNT24_DP_BLINK_EN
  output logic [cnt_width(SEC1_MAX)-1:0]         count,
`endif
  output logic                                   tick
);

  localparam int unsigned CNT_W = cnt_width(SEC1_MAX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SEC1_MAX - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(SEC1_MAX - 2);

  logic [CNT_W-1:0] cnt;

  // Free-running 0..SEC1_MAX-1 counter; tick is registered one count early so it is high while cnt==LAST.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE);
    end
  end

`ifdef COUNT24_DP_BLINK_EN
  assign count = cnt;
`endif

endmodule

// File: rtl/count_24.sv
// 24-hour BCD clock with set buttons, page select and a 4-digit multiplexed 7-seg drive.
// Optional: COUNT24_DP_BLINK_EN makes the separator dp blink at 1 Hz instead of staying lit.
module count_24 import count24_pkg::*; #(
  parameter int unsigned SEC1_MAX = 100000000,
  parameter int unsigned SCAN_MAX = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEL_DOWN,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic [7:0] LED7seg,
  output logic [3:0] SA
);

  localparam int unsigned SCAN_W = cnt_width(SCAN_MAX);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_MAX - 1);

  logic              tick;
  logic [2:0]        btn_m;
  logic [2:0]        btn_s;
  time_t             tm;
  time_t             tm_nxt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx;
  logic [15:0]       page_digits;
  bcd_t              digit;
  logic [7:0]        seg_nxt;
  logic [3:0]        sa_nxt;
  logic              dp_on;

`ifdef COUNT24_DP_BLINK_EN
  localparam int unsigned CNT_W = cnt_width(SEC1_MAX);
  logic [CNT_W-1:0] prescale;

  sec_tick #(.SEC1_MAX(SEC1_MAX)) i0 (
    .CLK   (CLK),
    .RESET (RESET),
    .count (prescale),
    .tick  (tick)
  );

  assign dp_on = (prescale < CNT_W'(SEC1_MAX / 2));
`else
  sec_tick #(.SEC1_MAX(SEC1_MAX)) i0 (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick)
  );

  assign dp_on = 1'b1;
`endif

  // Two-flop synchronizers for {BTN3, BTN2, BTN1}.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= {BTN3, BTN2, BTN1};
      btn_s <= btn_m;
    end
  end

  // Next time: normal count with carry/borrow, or set mode stepping hours/minutes independently.
  always_comb begin
    tm_nxt = tm;
    if (tick) begin
      if (btn_s[0] || btn_s[1]) begin
        {tm_nxt.s1, tm_nxt.s0} = 8'h00;
        if (btn_s[0])
          {tm_nxt.h1, tm_nxt.h0} = bcd2_step({tm.h1, tm.h0}, SEL_DOWN, HOUR_MAX_BCD);
        if (btn_s[1])
          {tm_nxt.m1, tm_nxt.m0} = bcd2_step({tm.m1, tm.m0}, SEL_DOWN, MIN_SEC_MAX_BCD);
      end else begin
        {tm_nxt.s1, tm_nxt.s0} = bcd2_step({tm.s1, tm.s0}, SEL_DOWN, MIN_SEC_MAX_BCD);
        if (bcd2_wraps({tm.s1, tm.s0}, SEL_DOWN, MIN_SEC_MAX_BCD)) begin
          {tm_nxt.m1, tm_nxt.m0} = bcd2_step({tm.m1, tm.m0}, SEL_DOWN, MIN_SEC_MAX_BCD);
          if (bcd2_wraps({tm.m1, tm.m0}, SEL_DOWN, MIN_SEC_MAX_BCD))
            {tm_nxt.h1, tm_nxt.h0} = bcd2_step({tm.h1, tm.h0}, SEL_DOWN, HOUR_MAX_BCD);
        end
      end
    end
  end

  // Time register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) tm <= '0;
    else       tm <= tm_nxt;
  end

  // Digit scan: index advances every SCAN_MAX cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Select the page digit under the scan index and build its segment/anode pattern.
  always_comb begin
    page_digits = btn_s[2] ? {tm.m1, tm.m0, tm.s1, tm.s0} : {tm.h1, tm.h0, tm.m1, tm.m0};
    digit       = '0;
    case (scan_idx)
      2'd0:    digit = page_digits[3:0];
      2'd1:    digit = page_digits[7:4];
      2'd2:    digit = page_digits[11:8];
      default: digit = page_digits[15:12];
    endcase
    seg_nxt = bcd_to_seg(digit);
    if (scan_idx == 2'd2 && dp_on) seg_nxt[7] = 1'b0;
    sa_nxt = ~(4'b0001 << scan_idx);
  end

  // Segments and anodes share one register stage so they always change together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SA      <= 4'b1110;
      LED7seg <= SEG_0;
    end else begin
      SA      <= sa_nxt;
      LED7seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_count_24.sv
// Directed bench for count_24: fast prescaler, one-cycle scan, hand-computed times and segments.
module tb_count_24;

  logic       CLK;
  logic       RESET;
  logic       SEL_DOWN;
  logic       BTN1;
  logic       BTN2;
  logic       BTN3;
  logic [7:0] LED7seg;
  logic [3:0] SA;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  count_24 #(.SEC1_MAX(4), .SCAN_MAX(1)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SEL_DOWN (SEL_DOWN),
    .BTN1     (BTN1),
    .BTN2     (BTN2),
    .BTN3     (BTN3),
    .LED7seg  (LED7seg),
    .SA       (SA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [23:0] exp);
    chk(tag, {8'h00, dut.tm}, {8'h00, exp});
  endtask

  // Let n ticks be applied; returns on the falling edge after the last tick edge.
  task automatic wait_tick(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      while (dut.tick !== 1'b1 && guard < 16) begin
        @(negedge CLK);
        guard++;
      end
      if (dut.tick !== 1'b1) begin
        chk("tick_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  // Watch four scan steps; digs = {digit3, digit2, digit1, digit0}.
  task automatic check_scan(input logic [15:0] digs);
    logic [3:0] prev;
    logic [7:0] exp;
    int idx;
    prev = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      case (SA)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (k == 0) chk("scan_sa_onehot", {31'd0, idx >= 0}, 32'd1);
      else        chk("scan_sa_order", {28'd0, SA}, {28'd0, prev[2:0], prev[3]});
      if (idx >= 0) begin
        exp = seg_tab[digs[idx*4 +: 4]];
        if (idx == 2) exp[7] = 1'b0;
        chk("scan_led", {24'd0, LED7seg}, {24'd0, exp});
      end
      prev = SA;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; SEL_DOWN = 1'b0; BTN1 = 1'b0; BTN2 = 1'b0; BTN3 = 1'b1;
    #50;
    chk_time("reset_time", 24'h000000);
    chk("reset_sa", {28'd0, SA}, 32'h0000000E);
    chk("reset_led", {24'd0, LED7seg}, 32'h000000C0);
    #50;
    RESET = 1'b0;

    wait_tick(1);   chk_time("first_tick", 24'h000001);
    check_scan(16'h0001);

    BTN3 = 1'b0; SEL_DOWN = 1'b1; BTN1 = 1'b1; BTN2 = 1'b1;
    wait_tick(1);   chk_time("set_both_down", 24'h235900);
    BTN1 = 1'b0; BTN2 = 1'b0; SEL_DOWN = 1'b0;
    wait_tick(59);  chk_time("count_to_235959", 24'h235959);
    wait_tick(1);   chk_time("wrap_up", 24'h000000);
    SEL_DOWN = 1'b1;
    wait_tick(1);   chk_time("wrap_down", 24'h235959);

    SEL_DOWN = 1'b0; BTN1 = 1'b1; BTN2 = 1'b1;
    wait_tick(1);   chk_time("set_both_up_wrap", 24'h000000);
    BTN2 = 1'b0;
    wait_tick(10);  chk_time("set_hr_10", 24'h100000);
    BTN1 = 1'b0;
    wait_tick(5);   chk_time("count_100005", 24'h100005);
    SEL_DOWN = 1'b1; BTN2 = 1'b1;
    wait_tick(3);   chk_time("set_min_down", 24'h105700);
    wait_tick(57);  chk_time("set_min_down_00", 24'h100000);
    wait_tick(1);   chk_time("set_min_down_wrap", 24'h105900);

    BTN2 = 1'b0; BTN1 = 1'b1;
    wait_tick(12);  chk_time("set_hr_down_wrap", 24'h225900);
    BTN1 = 1'b0; BTN2 = 1'b1;
    wait_tick(29);  chk_time("set_min_30", 24'h223000);
    BTN2 = 1'b0; SEL_DOWN = 1'b0;
    wait_tick(15);  chk_time("count_223015", 24'h223015);
    BTN1 = 1'b1;
    wait_tick(3);   chk_time("set_hr_up_wrap", 24'h013000);
    wait_tick(11);  chk_time("set_hr_12", 24'h123000);
    BTN1 = 1'b0; BTN2 = 1'b1;
    wait_tick(4);   chk_time("set_min_34", 24'h123400);
    BTN2 = 1'b0;
    check_scan(16'h1234);

    BTN1 = 1'b1; SEL_DOWN = 1'b1;
    wait_tick(5);   chk_time("set_hr_07", 24'h073400);
    BTN1 = 1'b0; BTN2 = 1'b1; SEL_DOWN = 1'b0;
    wait_tick(11);  chk_time("set_min_45", 24'h074500);
    BTN2 = 1'b0;
    wait_tick(12);  chk_time("count_074512", 24'h074512);

    #2 RESET = 1'b1;
    #1;
    chk_time("async_reset_time", 24'h000000);
    chk("async_reset_sa", {28'd0, SA}, 32'h0000000E);
    chk("async_reset_led", {24'd0, LED7seg}, 32'h000000C0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_24.md
# count_24

Top-level 24-hour digital clock for the FPGA board. A prescaler in the `sec_tick` sub-module divides the board clock down to a 1 Hz tick. BCD hour, minute and second counters count up or down on each tick, and three buttons set the time or select the page. Four multiplexed common-anode 7-segment digits are driven directly from this block.

## Interface
Parameters:
- SEC1_MAX, 100000000: clock cycles per 1 s tick. It lives on instance `i0` (`sec_tick`) and is overridable hierarchically as i0.SEC1_MAX. Must be ≥2.
- SCAN_MAX, 1000: clock cycles each digit stays lit. Must be ≥1.

Ports:
- CLK, in, 1: the single clock.
- RESET, in, 1: asynchronous, active-high reset.
- SEL_DOWN, in, 1: count direction. 0 = up, 1 = down.
- BTN1, in, 1: hour set. Active-high, level, held.
- BTN2, in, 1: minute set. Active-high, level, held.
- BTN3, in, 1: page select. 0 = HH.MM, 1 = MM.SS.
- LED7seg, out, 8: segments, active-low. [7]=dp, [6]=g … [0]=a.
- SA, out, 4: digit anodes, active-low. SA[3] is the leftmost digit.

## Operation
- Time state: six BCD digits H1 (0–2), H0, M1 (0–5), M0, S1 (0–5), S0. Valid range is 00:00:00–23:59:59.
- Prescaler: counts 0..SEC1_MAX-1 and wraps. It pulses `tick` for one cycle when the count equals SEC1_MAX-1.
- Buttons: BTN1, BTN2 and BTN3 each pass through a 2-flop synchronizer before use.
- Normal counting, on tick with both set buttons low:
  - SEL_DOWN=0: increment seconds, with carry into minutes, then hours. 23:59:59 → 00:00:00.
  - SEL_DOWN=1: decrement seconds, with borrow. 00:00:00 → 23:59:59.
- Set mode, on tick with BTN1 or BTN2 high:
  - Seconds are forced to 00.
  - BTN1 steps hours by ±1 per SEL_DOWN: 23→00 up, 00→23 down. No carry into anything.
  - BTN2 steps minutes by ±1: 59↔00 wrap. No carry into hours.
  - Both high: both step on the same tick.
- Display page: HH.MM when BTN3=0, MM.SS when BTN3=1. Leading zeros are shown.
- Scan: a 2-bit digit index advances every SCAN_MAX cycles, in the order digit0 → digit3 → wrap.
  - SA is one-hot low for the selected digit.
  - LED7seg shows the hex-to-7-seg decode of that digit.
  - Codes 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (dp included, off).
  - Any other code shows FF (blank).
- dp: lit only on digit2 (the separator), subject to Configuration.

## Timing
- Reset values: all time digits 0; prescaler 0; scan index 0; SA=4'b1110; LED7seg=8'hC0; synchronizer flops 0.
- First tick comes SEC1_MAX cycles after reset deassertion.
- Time registers update on the clock edge where tick=1.
- Button-to-effect latency: 2 cycles of synchronization, then the next tick.
- SEL_DOWN is sampled directly at the tick edge. It is quasi-static and unsynchronized.
- LED7seg and SA are registered and update together, one cycle after the scan-index change. Both come from the same flop stage, so there is no ghosting mismatch between them.
- Reset mid-count returns to 00:00:00 immediately (asynchronous).
- Changing SEL_DOWN between ticks takes effect on the next tick with no skipped or doubled step.

## Configuration
- COUNT24_DP_BLINK_EN
  - Defined: the digit2 dp is lit only while prescaler < SEC1_MAX/2 (first half-second), i.e. it blinks at 1 Hz.
  - Undefined: the digit2 dp is lit continuously.

## Structure
- Package `count24_pkg`:
  - 4-bit BCD digit typedef.
  - Constants HOUR_MAX=23 and MIN_SEC_MAX=59.
  - The 7-seg code constants and blank code FF.
  - Function bcd_to_seg.
- Sub-module `sec_tick`, instance name i0: parameter SEC1_MAX, ports CLK/RESET/tick (and the prescaler count for the dp blink).
- The time counters, set logic and scan mux stay in count24.

## Test plan
- SEC1_MAX=2, RESET for 100 ns, then all inputs 0 → after 24·3600 ticks time returns to 00:00:00. At tick 1 the time is 00:00:01. BTN3=1 shows digits 0,0,0,1.
- Count up to 23:59:59, one tick → 00:00:00. SEL_DOWN=1 from 00:00:00, one tick → 23:59:59.
- SEL_DOWN=1, BTN2=1 held from 10:00:xx, 3 ticks → 10:57:00, seconds 00, hours unchanged. Continue to 00 → next tick 59.
- BTN1=1, SEL_DOWN=0 from 22:30:15, 3 ticks → 01:30:00. BTN1 and BTN2 held from 23:59 → 00:00.
- Scan with SCAN_MAX=1 at 12:34 (BTN3=0): SA cycles 1110, 1101, 1011, 0111. LED7seg shows 99, B0, A4, F9 respectively. dp low only on SA=1011.
- Assert RESET mid-count at 07:45:12 → SA=1110, LED7seg=C0, time 00:00:00 within the same cycle.
